// File: rtl/btb_update_ctrl_if.sv
// Resolve-stage handshake, fetch redirect/prediction and BTB write-port bundle
// for btb_update_ctrl. The controller is the slave; its environment is the master.
interface btb_update_ctrl_if #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned IDX_BITS  = 8
);
    logic                          resolve_valid;
    logic                          resolve_ready;
    logic                          resolve_is_branch;
    logic                          resolve_taken;
    logic [WORD_SIZE-1:0]          resolve_pc;
    logic [WORD_SIZE-1:0]          resolve_target;
    logic [WORD_SIZE-1:0]          predicted_pc;
    logic                          flush;
    logic [WORD_SIZE-1:0]          redirect_pc;
    logic                          predict_taken;
    logic                          btb_we;
    logic [IDX_BITS-1:0]           btb_index;
    logic [WORD_SIZE-IDX_BITS-1:0] btb_tag;
    logic [WORD_SIZE-1:0]          btb_target;
    logic                          init_busy;

    modport master (
        output resolve_valid, resolve_is_branch, resolve_taken,
               resolve_pc, resolve_target, predicted_pc,
        input  resolve_ready, flush, redirect_pc, predict_taken,
               btb_we, btb_index, btb_tag, btb_target, init_busy
    );

    modport slave (
        input  resolve_valid, resolve_is_branch, resolve_taken,
               resolve_pc, resolve_target, predicted_pc,
        output resolve_ready, flush, redirect_pc, predict_taken,
               btb_we, btb_index, btb_tag, btb_target, init_busy
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write-port owner: invalidates all entries after reset, then resolves branches,
// raises flush/redirect on mispredict, trains the 2-bit counter and queues BTB writes.
module btb_update_ctrl #(
    parameter int unsigned          WORD_SIZE      = 16,
    parameter int unsigned          IDX_BITS       = 8,
    parameter logic [WORD_SIZE-1:0] INVALID_TARGET = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    btb_update_ctrl_if.slave bus
);
    localparam int unsigned TAG_BITS = WORD_SIZE - IDX_BITS;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [IDX_BITS-1:0]  index;
        logic [TAG_BITS-1:0]  tag;
        logic [WORD_SIZE-1:0] target;
    } wr_t;

    state_t               state, state_next;
    logic                 busy;
    logic [IDX_BITS-1:0]  init_cnt;
    wr_t                  q [2];
    logic [1:0]           count;
    logic [1:0]           counter;

    logic                 flush_r;
    logic [WORD_SIZE-1:0] redirect_r;
    logic                 we_r;
    logic [IDX_BITS-1:0]  index_r;
    logic [TAG_BITS-1:0]  tag_r;
    logic [WORD_SIZE-1:0] target_r;

    logic                 ready;
    logic                 accept;
    logic                 branch_accept;
    logic [WORD_SIZE-1:0] actual;
    logic                 mispredict;
    logic                 push;
    logic                 pop;
    wr_t                  new_entry;

    // Ready depends only on the registered count, so a same-cycle pop never raises it.
    assign ready         = (count < 2'd2);
    assign accept        = bus.resolve_valid & ready;
    assign branch_accept = accept & bus.resolve_is_branch;
    assign actual        = bus.resolve_taken ? bus.resolve_target
                                             : bus.resolve_pc + WORD_SIZE'(1);
    assign mispredict    = branch_accept & (actual != bus.predicted_pc);
    assign push          = branch_accept & bus.resolve_taken;
    assign pop           = (state == RUN) & (count != 2'd0);

    assign new_entry.index  = bus.resolve_pc[IDX_BITS-1:0];
    assign new_entry.tag    = bus.resolve_pc[WORD_SIZE-1:IDX_BITS];
    assign new_entry.target = bus.resolve_target;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            INIT: begin
                busy = 1'b1;
                if (init_cnt == '1) begin
                    state_next = RUN;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // BTB write port: sweep writes during INIT, queue pops during RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt <= '0;
            we_r     <= 1'b0;
            index_r  <= '0;
            tag_r    <= '0;
            target_r <= '0;
        end else if (state == INIT) begin
            we_r     <= 1'b1;
            index_r  <= init_cnt;
            tag_r    <= '0;
            target_r <= INVALID_TARGET;
            init_cnt <= init_cnt + IDX_BITS'(1);
        end else if (pop) begin
            we_r     <= 1'b1;
            index_r  <= q[0].index;
            tag_r    <= q[0].tag;
            target_r <= q[0].target;
        end else begin
            we_r     <= 1'b0;
        end
    end

    // Two-entry FIFO; q[0] is the head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q[0]  <= '0;
            q[1]  <= '0;
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        q[0] <= new_entry;
                    end else begin
                        q[1] <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q[0]  <= q[1];
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q[0] <= new_entry;
                    end else begin
                        q[0] <= q[1];
                        q[1] <= new_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter    <= 2'b00;
            flush_r    <= 1'b0;
            redirect_r <= '0;
        end else begin
            flush_r <= mispredict;
            if (mispredict) begin
                redirect_r <= actual;
            end
            if (branch_accept) begin
                if (bus.resolve_taken && counter != 2'b11) begin
                    counter <= counter + 2'd1;
                end else if (!bus.resolve_taken && counter != 2'b00) begin
                    counter <= counter - 2'd1;
                end
            end
        end
    end

    assign bus.resolve_ready = ready;
    assign bus.flush         = flush_r;
    assign bus.redirect_pc   = redirect_r;
    assign bus.predict_taken = counter[1];
    assign bus.btb_we        = we_r;
    assign bus.btb_index     = index_r;
    assign bus.btb_tag       = tag_r;
    assign bus.btb_target    = target_r;
    assign bus.init_busy     = busy;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed table, multi-cycle corner sequences and random
// traffic, all checked against a queue-based reference model of the controller.
module tb_btb_update_ctrl;
    localparam int unsigned W  = 16;
    localparam int unsigned IB = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    btb_update_ctrl_if #(.WORD_SIZE(W), .IDX_BITS(IB)) bus ();

    btb_update_ctrl #(
        .WORD_SIZE     (W),
        .IDX_BITS      (IB),
        .INVALID_TARGET(16'hFFFF)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending writes as a plain queue, sweep position, integer counter.
    typedef struct {
        logic [15:0] pc;
        logic [15:0] tgt;
    } mwr_t;

    mwr_t        mq [$];
    int          sweep_pos;
    int          ctr;
    logic        e_flush;
    logic [15:0] e_redir;
    logic        e_we;
    logic [15:0] e_wpc;
    logic [15:0] e_wtgt;
    bit          last_acc;

    typedef struct {
        logic        br;
        logic        tk;
        logic [15:0] pc;
        logic [15:0] tgt;
        logic [15:0] pred;
        logic        x_flush;
        logic [15:0] x_redir;
        logic        x_pt;
        logic        x_we;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sweep_pos = 0;
        ctr       = 0;
        e_flush   = 1'b0;
        e_we      = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_flush",    32'(bus.flush),         32'd0);
        chk("rst_redirect", 32'(bus.redirect_pc),   32'd0);
        chk("rst_we",       32'(bus.btb_we),        32'd0);
        chk("rst_index",    32'(bus.btb_index),     32'd0);
        chk("rst_tag",      32'(bus.btb_tag),       32'd0);
        chk("rst_target",   32'(bus.btb_target),    32'd0);
        chk("rst_predict",  32'(bus.predict_taken), 32'd0);
        chk("rst_busy",     32'(bus.init_busy),     32'd1);
        chk("rst_ready",    32'(bus.resolve_ready), 32'd1);
    endtask

    // Drive one cycle of inputs, advance the model by one edge, compare every output.
    task automatic cycle(input logic v, input logic br, input logic tk,
                         input logic [15:0] pc, input logic [15:0] tgt, input logic [15:0] pred);
        logic [15:0] actual;
        mwr_t        w;
        bit          acc;
        bus.resolve_valid     = v;
        bus.resolve_is_branch = br;
        bus.resolve_taken     = tk;
        bus.resolve_pc        = pc;
        bus.resolve_target    = tgt;
        bus.predicted_pc      = pred;

        acc = v && (mq.size() < 2);
        if (sweep_pos < 256) begin
            e_we   = 1'b1;
            e_wpc  = 16'(sweep_pos);
            e_wtgt = 16'hFFFF;
            sweep_pos++;
        end else if (mq.size() > 0) begin
            w      = mq.pop_front();
            e_we   = 1'b1;
            e_wpc  = w.pc;
            e_wtgt = w.tgt;
        end else begin
            e_we = 1'b0;
        end
        actual  = tk ? tgt : 16'(pc + 16'd1);
        e_flush = acc && br && (actual != pred);
        if (e_flush) e_redir = actual;
        if (acc && br) ctr = tk ? ((ctr == 3) ? 3 : ctr + 1) : ((ctr == 0) ? 0 : ctr - 1);
        if (acc && br && tk) mq.push_back('{pc, tgt});
        last_acc = acc;

        @(posedge clk);
        @(negedge clk);
        chk("ready",   32'(bus.resolve_ready), 32'(mq.size() < 2));
        chk("flush",   32'(bus.flush),         32'(e_flush));
        if (e_flush) chk("redirect", 32'(bus.redirect_pc), 32'(e_redir));
        chk("predict", 32'(bus.predict_taken), 32'(ctr >= 2));
        chk("busy",    32'(bus.init_busy),     32'(sweep_pos < 256));
        chk("we",      32'(bus.btb_we),        32'(e_we));
        if (e_we) begin
            chk("index",  32'(bus.btb_index),  32'(e_wpc[7:0]));
            chk("tag",    32'(bus.btb_tag),    32'(e_wpc[15:8]));
            chk("target", 32'(bus.btb_target), 32'(e_wtgt));
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    endtask

    initial begin
        logic [15:0] seen [$];
        logic [15:0] pc, tgt, pred, act;
        logic        v, br, tk;
        bit          accepted;
        bit          stray;

        tbl[0] = '{1'b1, 1'b1, 16'h1234, 16'h1240, 16'h1235, 1'b1, 16'h1240, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 16'h0100, 16'h0200, 16'h0200, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 16'h0300, 16'h0350, 16'h0350, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 16'h0400, 16'h0410, 16'h0410, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 16'h0010, 16'h0050, 16'h0020, 1'b1, 16'h0011, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 16'h0500, 16'h0000, 16'h9999, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 16'h0600, 16'h0000, 16'h0601, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 16'h0700, 16'h0000, 16'h0701, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 16'h0034, 16'h2000, 16'h0035, 1'b1, 16'h2000, 1'b0, 1'b1};

        bus.resolve_valid     = 1'b0;
        bus.resolve_is_branch = 1'b0;
        bus.resolve_taken     = 1'b0;
        bus.resolve_pc        = '0;
        bus.resolve_target    = '0;
        bus.predicted_pc      = '0;
        model_reset();

        // Power-on reset and full invalidation sweep.
        @(negedge clk);
        #1 check_reset_values();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            idle();
            if (i == 0) chk("sweep_first_index", 32'(bus.btb_index), 32'd0);
        end
        idle();
        chk("sweep_over_we",   32'(bus.btb_we),    32'd0);
        chk("sweep_over_busy", 32'(bus.init_busy), 32'd0);

        // Directed table: one accept, then one idle cycle for the queued write to appear.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, tbl[i].br, tbl[i].tk, tbl[i].pc, tbl[i].tgt, tbl[i].pred);
            chk("tbl_flush", 32'(bus.flush), 32'(tbl[i].x_flush));
            if (tbl[i].x_flush) chk("tbl_redirect", 32'(bus.redirect_pc), 32'(tbl[i].x_redir));
            chk("tbl_predict", 32'(bus.predict_taken), 32'(tbl[i].x_pt));
            idle();
            chk("tbl_we", 32'(bus.btb_we), 32'(tbl[i].x_we));
            if (tbl[i].x_we) begin
                chk("tbl_index",  32'(bus.btb_index),  32'(tbl[i].pc[7:0]));
                chk("tbl_tag",    32'(bus.btb_tag),    32'(tbl[i].pc[15:8]));
                chk("tbl_target", 32'(bus.btb_target), 32'(tbl[i].tgt));
            end
        end

        // Back-to-back mispredicts to the same BTB index: two flushes, writes in order.
        cycle(1'b1, 1'b1, 1'b1, 16'h1155, 16'h2000, 16'h0000);
        chk("b2b_flush0", 32'(bus.flush), 32'd1);
        chk("b2b_redir0", 32'(bus.redirect_pc), 32'h2000);
        cycle(1'b1, 1'b1, 1'b1, 16'h2255, 16'h3000, 16'h0000);
        chk("b2b_flush1", 32'(bus.flush), 32'd1);
        chk("b2b_redir1", 32'(bus.redirect_pc), 32'h3000);
        chk("b2b_wr0_tag", 32'(bus.btb_tag), 32'h11);
        idle();
        chk("b2b_flush_end", 32'(bus.flush), 32'd0);
        chk("b2b_wr1_tag",   32'(bus.btb_tag), 32'h22);
        chk("b2b_wr1_index", 32'(bus.btb_index), 32'h55);
        idle();

        // Accepts during INIT fill the queue; a third result is held until RUN drains it.
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1 check_reset_values();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 16'hA010, 16'hA100, 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 16'hA020, 16'hA200, 16'hA200);
        chk("init_full_ready", 32'(bus.resolve_ready), 32'd0);
        accepted = 1'b0;
        for (int k = 0; k < 300 && !accepted; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 16'hB000, 16'h0000, 16'hB001);
            accepted = last_acc;
            if (k == 100) chk("init_hold_ready", 32'(bus.resolve_ready), 32'd0);
            if (bus.btb_we && bus.btb_target != 16'hFFFF) seen.push_back({bus.btb_tag, bus.btb_index});
        end
        chk("held_result_accepted", 32'(accepted), 32'd1);
        for (int k = 0; k < 3; k++) begin
            idle();
            if (bus.btb_we && bus.btb_target != 16'hFFFF) seen.push_back({bus.btb_tag, bus.btb_index});
        end
        chk("init_q_writes", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("init_q_first",  32'(seen[0]), 32'hA010);
            chk("init_q_second", 32'(seen[1]), 32'hA020);
        end

        // Reset with one write queued and a saturated counter.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 16'hC001 + 16'(k), 16'hD000 + 16'(k), 16'hD000 + 16'(k));
        end
        chk("pre_reset_predict", 32'(bus.predict_taken), 32'd1);
        reset_n = 1'b0;
        model_reset();
        #1 check_reset_values();
        @(negedge clk);
        reset_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 257; i++) begin
            idle();
            if (i == 0) chk("restart_index", 32'(bus.btb_index), 32'd0);
            if (bus.btb_we && bus.btb_target != 16'hFFFF) stray = 1'b1;
        end
        chk("discarded_write", 32'(stray), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            v   = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 9) < 7);
            tk  = 1'($urandom_range(0, 1));
            pc  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            tgt = 16'($urandom);
            act = tk ? tgt : 16'(pc + 16'd1);
            pred = ($urandom_range(0, 1) == 1) ? act : 16'($urandom);
            cycle(v, br, tk, pc, tgt, pred);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
